// File: rtl/link_test_pkg.sv
// Shared definitions for the board-to-board link self-test.
//   DATA_W    : width of a link word
//   DEF_CNT_W : default width of the status counters
//   DEF_SEED  : default value of word 0 of the test pattern
//   state_e   : sequencer states (3-bit encoding)
package link_test_pkg;

  localparam int DATA_W    = 32;
  localparam int DEF_CNT_W = 16;
  localparam logic [DATA_W-1:0] DEF_SEED = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_PASS  = 3'd4,
    ST_FAIL  = 3'd5
  } state_e;

endpackage

// File: rtl/link_rx_checker.sv
// Receive-side checker for the link self-test.
// Compares every qualified received word against the incrementing pattern
// SEED + recv_count and keeps the received-word and error counters.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clr_i          : clears both counters (start of a run)
//   active_i       : received words are only examined while high
//   rx_valid_i     : one-cycle strobe qualifying rx_data_i
//   rx_data_i      : received word
//   recv_count_o   : words accepted this run (stops at RECEIVE_COUNT)
//   err_count_o    : mismatches plus overflow words, saturating
//   err_next_o     : value err_count_o takes at the next edge
module link_rx_checker
  import link_test_pkg::*;
#(
  parameter int unsigned       RECEIVE_COUNT = 100,
  parameter logic [DATA_W-1:0] SEED          = DEF_SEED,
  parameter int unsigned       CNT_W         = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              active_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic [CNT_W-1:0]  recv_count_o,
  output logic [CNT_W-1:0]  err_count_o,
  output logic [CNT_W-1:0]  err_next_o
);

  localparam logic [CNT_W-1:0] RECV_FULL = CNT_W'(RECEIVE_COUNT);

  logic [CNT_W-1:0]  recv_q, recv_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [DATA_W-1:0] expected;
  logic              take, overflow, err_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    expected = SEED + DATA_W'(recv_q);
    take     = active_i & rx_valid_i;
    // Once the expected number of words has arrived, any further word is an
    // error by itself, whatever its value.
    overflow = (recv_q == RECV_FULL);
    err_hit  = take & (overflow | (rx_data_i != expected));
    recv_d   = recv_q;
    err_d    = err_q;
    if (clr_i) begin
      recv_d = '0;
      err_d  = '0;
    end else begin
      if (take && !overflow) recv_d = recv_q + CNT_W'(1);
      if (err_hit)           err_d  = sat_inc(err_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      recv_q <= '0;
      err_q  <= '0;
    end else begin
      recv_q <= recv_d;
      err_q  <= err_d;
    end
  end

  assign recv_count_o = recv_q;
  assign err_count_o  = err_q;
  assign err_next_o   = err_d;

endmodule

// File: rtl/link_test_ctrl.sv
// Board-to-board link self-test sequencer.
// Feeds SEND_COUNT incrementing words to the sender over a start/done
// handshake, checks the words coming back from the receiver, runs an idle
// watchdog and reports the verdict on two sticky LEDs.
//   clk, rst          : clock, synchronous active-high reset
//   en                : level-sensitive run enable
//   tx_start, tx_data : request and word towards the sender
//   tx_done           : sender finished the current word
//   rx_valid, rx_data : received word strobe and value
//   busy              : run in progress (SEND, GAP, DRAIN)
//   led_pass/led_fail : verdict of the last completed run
//   sent_count, recv_count, err_count : status counters of the current run
module link_test_ctrl
  import link_test_pkg::*;
#(
  parameter int unsigned       SEND_COUNT    = 100,
  parameter int unsigned       RECEIVE_COUNT = 100,
  parameter logic [DATA_W-1:0] SEED          = DEF_SEED,
  parameter int unsigned       TIMEOUT       = 1024,
  parameter int unsigned       CNT_W         = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              led_pass,
  output logic              led_fail,
  output logic [CNT_W-1:0]  sent_count,
  output logic [CNT_W-1:0]  recv_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned      WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SENT_LAST = CNT_W'(SEND_COUNT - 1);
  localparam logic [CNT_W-1:0] RECV_FULL = CNT_W'(RECEIVE_COUNT);

  state_e            state_q;
  logic              tx_start_q, busy_q, pass_q, fail_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [CNT_W-1:0]  sent_q;
  logic [WD_W-1:0]   wd_q;
  logic [CNT_W-1:0]  err_next;
  logic              chk_clr, chk_active, evt, wd_expire;

  // Any handshake activity, counted or not, proves the link is alive.
  assign evt        = tx_done | rx_valid;
  assign wd_expire  = (wd_q == WD_LAST) & ~evt;
  assign chk_clr    = (state_q == ST_IDLE) & en;
  // The abort cycle (en low) must leave the counters untouched.
  assign chk_active = busy_q & en;

  link_rx_checker #(
    .RECEIVE_COUNT (RECEIVE_COUNT),
    .SEED          (SEED),
    .CNT_W         (CNT_W)
  ) u_rx_checker (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (chk_clr),
    .active_i     (chk_active),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .recv_count_o (recv_count),
    .err_count_o  (err_count),
    .err_next_o   (err_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= SEED;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      sent_q     <= '0;
      wd_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q    <= ST_SEND;
            tx_start_q <= 1'b1;
            tx_data_q  <= SEED;
            busy_q     <= 1'b1;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            sent_q     <= '0;
            wd_q       <= '0;
          end
        end
        ST_SEND, ST_GAP, ST_DRAIN: begin
          if (!en) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            wd_q       <= '0;
          end else if (wd_expire) begin
            // Timeout wins over a completion in the same cycle.
            state_q    <= ST_FAIL;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            fail_q     <= 1'b1;
            wd_q       <= '0;
          end else begin
            wd_q <= evt ? '0 : wd_q + WD_W'(1);
            case (state_q)
              ST_SEND: begin
                if (tx_done) begin
                  sent_q     <= sent_q + CNT_W'(1);
                  tx_start_q <= 1'b0;
                  tx_data_q  <= tx_data_q + DATA_W'(1);
                  state_q    <= (sent_q < SENT_LAST) ? ST_GAP : ST_DRAIN;
                end
              end
              ST_GAP: begin
                state_q    <= ST_SEND;
                tx_start_q <= 1'b1;
              end
              default: begin
                // Verdict includes an overflow word arriving this very cycle.
                if (recv_count == RECV_FULL) begin
                  busy_q <= 1'b0;
                  wd_q   <= '0;
                  if (err_next == '0) begin
                    state_q <= ST_PASS;
                    pass_q  <= 1'b1;
                  end else begin
                    state_q <= ST_FAIL;
                    fail_q  <= 1'b1;
                  end
                end
              end
            endcase
          end
        end
        ST_PASS, ST_FAIL: begin
          if (!en) state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_start_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign led_pass   = pass_q;
  assign led_fail   = fail_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_link_test_ctrl.sv
// Self-checking bench for link_test_ctrl: directed runs against a behavioural
// model of the self-test rules, plus hand-computed expectations per run.
module tb_link_test_ctrl;

  localparam int          SEND_N  = 4;
  localparam int          RECV_N  = 4;
  localparam logic [31:0] SEED    = 32'h0000_0001;
  localparam int          TMO     = 16;
  localparam int          CW      = 16;
  localparam int          ERR_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          tx_start;
  logic [31:0]   tx_data;
  logic          tx_done = 1'b0;
  logic          rx_valid = 1'b0;
  logic [31:0]   rx_data = '0;
  logic          busy, led_pass, led_fail;
  logic [CW-1:0] sent_count, recv_count, err_count;

  int tests = 0;
  int fails = 0;

  link_test_ctrl #(
    .SEND_COUNT    (SEND_N),
    .RECEIVE_COUNT (RECV_N),
    .SEED          (SEED),
    .TIMEOUT       (TMO),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .busy       (busy),
    .led_pass   (led_pass),
    .led_fail   (led_fail),
    .sent_count (sent_count),
    .recv_count (recv_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A run is "active" while words remain to be sent or returned; the word on
  // offer is always SEED + words already sent; one idle cycle follows every
  // accepted word except the last.
  bit m_ok = 0, m_run = 0, m_gap = 0, m_done = 0, m_pass = 0, m_fail = 0;
  int m_sent = 0, m_recv = 0, m_err = 0, m_idle = 0;

  always @(posedge clk) begin
    bit drained;
    int recv_before;
    if (rst) begin
      m_ok = 1; m_run = 0; m_gap = 0; m_done = 0; m_pass = 0; m_fail = 0;
      m_sent = 0; m_recv = 0; m_err = 0; m_idle = 0;
    end else if (m_ok) begin
      if (!m_run) begin
        if (m_done) begin
          if (!en) m_done = 0;
        end else if (en) begin
          m_run = 1; m_gap = 0; m_pass = 0; m_fail = 0;
          m_sent = 0; m_recv = 0; m_err = 0; m_idle = 0;
        end
      end else if (!en) begin
        m_run = 0;
      end else begin
        m_idle      = (tx_done || rx_valid) ? 0 : m_idle + 1;
        recv_before = m_recv;
        drained     = (m_sent == SEND_N);
        if (rx_valid) begin
          if (m_recv == RECV_N) m_err = (m_err < ERR_MAX) ? m_err + 1 : m_err;
          else begin
            if (rx_data != 32'(SEED + m_recv)) m_err = (m_err < ERR_MAX) ? m_err + 1 : m_err;
            m_recv++;
          end
        end
        if (m_gap) m_gap = 0;
        else if (!drained && tx_done) begin
          m_sent++;
          m_gap = (m_sent < SEND_N);
        end
        if (m_idle >= TMO) begin
          m_run = 0; m_done = 1; m_fail = 1;
        end else if (drained && recv_before == RECV_N) begin
          m_run = 0; m_done = 1;
          m_pass = (m_err == 0);
          m_fail = (m_err != 0);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_ok) begin
      chk("tx_start",   32'(tx_start),   32'(m_run && !m_gap && m_sent < SEND_N));
      chk("tx_data",    tx_data,         32'(SEED + m_sent));
      chk("busy",       32'(busy),       32'(m_run));
      chk("led_pass",   32'(led_pass),   32'(m_pass));
      chk("led_fail",   32'(led_fail),   32'(m_fail));
      chk("sent_count", 32'(sent_count), 32'(m_sent));
      chk("recv_count", 32'(recv_count), 32'(m_recv));
      chk("err_count",  32'(err_count),  32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] txq[$];

  task automatic wait_tx_start(output bit ok);
    int n = 0;
    while (!tx_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = tx_start;
    if (!ok) bound_fail("wait_tx_start");
  endtask

  // Sender acks after ack_dly cycles; optional rx word with or after tx_done.
  task automatic send_word(input int ack_dly, input bit do_rx, input logic [31:0] rxw, input bit rx_same);
    bit ok;
    wait_tx_start(ok);
    if (!ok) return;
    repeat (ack_dly - 1) @(negedge clk);
    txq.push_back(tx_data);
    tx_done = 1'b1;
    if (do_rx && rx_same) begin
      rx_valid = 1'b1;
      rx_data  = rxw;
    end
    @(negedge clk);
    tx_done  = 1'b0;
    rx_valid = 1'b0;
    if (do_rx && !rx_same) begin
      rx_valid = 1'b1;
      rx_data  = rxw;
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop_run();
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_verdict(input string name);
    int n = 0;
    while (!(led_pass || led_fail) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!(led_pass || led_fail)) bound_fail(name);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cnt;
    bit ok;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data",  tx_data,       32'h0000_0001);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_leds",     32'({led_pass, led_fail}), 32'd0);
    chk("rst_counts",   32'(sent_count | recv_count | err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Clean loop: words 1..4 echoed back
    txq.delete();
    start_run();
    for (int i = 0; i < 4; i++) send_word(2, 1'b1, 32'(SEED + i), 1'b0);
    wait_verdict("clean_verdict");
    chk("clean_pass", 32'(led_pass), 32'd1);
    chk("clean_fail", 32'(led_fail), 32'd0);
    chk("clean_sent", 32'(sent_count), 32'd4);
    chk("clean_recv", 32'(recv_count), 32'd4);
    chk("clean_err",  32'(err_count),  32'd0);
    chk("clean_nwords", 32'(txq.size()), 32'd4);
    for (int i = 0; i < 4 && i < txq.size(); i++) chk("clean_txseq", txq[i], 32'(i + 1));
    stop_run();
    chk("clean_led_retained", 32'(led_pass), 32'd1);

    // Corrupted third word
    start_run();
    send_word(2, 1'b1, 32'h0000_0001, 1'b0);
    send_word(2, 1'b1, 32'h0000_0002, 1'b0);
    send_word(2, 1'b1, 32'h0000_0007, 1'b0);
    send_word(2, 1'b1, 32'h0000_0004, 1'b0);
    wait_verdict("corrupt_verdict");
    chk("corrupt_fail", 32'(led_fail), 32'd1);
    chk("corrupt_pass", 32'(led_pass), 32'd0);
    chk("corrupt_err",  32'(err_count),  32'd1);
    chk("corrupt_recv", 32'(recv_count), 32'd4);
    stop_run();

    // Watchdog: sender never answers
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("wd_tx_start", 32'(tx_start), 32'd1);
    cnt = 0;
    while (!led_fail && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("wd_latency", 32'(cnt), 32'd16);
    chk("wd_sent",    32'(sent_count), 32'd0);
    @(negedge clk);
    stop_run();

    // Simultaneous tx_done/rx_valid, then an overflow word
    start_run();
    for (int i = 0; i < 3; i++) send_word(2, 1'b1, 32'(SEED + i), 1'b1);
    wait_tx_start(ok);
    if (ok) begin
      rx_valid = 1'b1;
      rx_data  = 32'h0000_0004;
      @(negedge clk);
      tx_done  = 1'b1;
      rx_data  = 32'h0000_0005;
      @(negedge clk);
      tx_done  = 1'b0;
      rx_valid = 1'b0;
    end
    wait_verdict("ovf_verdict");
    chk("ovf_fail", 32'(led_fail), 32'd1);
    chk("ovf_err",  32'(err_count),  32'd1);
    chk("ovf_recv", 32'(recv_count), 32'd4);
    chk("ovf_sent", 32'(sent_count), 32'd4);
    stop_run();

    // Abort after 2 of 4 words, then re-enable
    start_run();
    send_word(2, 1'b1, 32'h0000_0001, 1'b0);
    send_word(2, 1'b1, 32'h0000_0002, 1'b0);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tx_start", 32'(tx_start), 32'd0);
    chk("abort_busy",     32'(busy),     32'd0);
    chk("abort_sent",     32'(sent_count), 32'd2);
    chk("abort_recv",     32'(recv_count), 32'd2);
    chk("abort_leds",     32'({led_pass, led_fail}), 32'd0);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("reen_tx_data",  tx_data, 32'h0000_0001);
    chk("reen_tx_start", 32'(tx_start), 32'd1);
    chk("reen_counts",   32'(sent_count | recv_count | err_count), 32'd0);
    @(negedge clk);
    stop_run();

    // Reset in the middle of a run
    start_run();
    send_word(2, 1'b1, 32'h0000_0001, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_tx_start", 32'(tx_start), 32'd0);
    chk("mrst_tx_data",  tx_data,       32'h0000_0001);
    chk("mrst_busy",     32'(busy),     32'd0);
    chk("mrst_counts",   32'(sent_count | recv_count | err_count), 32'd0);
    chk("mrst_leds",     32'({led_pass, led_fail}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (TMO + 10) @(negedge clk);
    chk("mrst_no_wd", 32'(led_fail), 32'd0);
    chk("mrst_idle",  32'(busy),     32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not complete");
    $fatal(1, "time limit");
  end

endmodule
